icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Miss-handling controller that sits between the fetch stage, the 128-entry x 64-bit direct-mapped instruction cache memory and the tagged instruction-memory bus.
- Splits the fetch address into index and tag and drives the cache read port. On a miss, it issues one bus load, tracks the returned transaction tag and writes the fill into the cache.
- Exactly one miss is outstanding at a time.

Parameters:
- IDX_W, 7, cache index width (128 lines, 8-byte blocks).
- TAG_W, 22, cache tag width; tag = proc2Icache_addr[IDX_W+TAG_W+2:IDX_W+3].
- MTAG_W, 4, memory transaction tag width; tag value 0 means "no transaction".

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- proc2Icache_addr  in  64  fetch PC; block address = addr[63:3]
- Icache_data_out  out  64  instruction block returned to fetch
- Icache_valid_out  out  1  Icache_data_out valid this cycle
- cache_rd_idx  out  IDX_W  cache memory read index (combinational from addr)
- cache_rd_tag  out  TAG_W  cache memory read tag (combinational from addr)
- cache_rd_data  in  64  cache memory read data
- cache_rd_valid  in  1  cache memory hit (valid and tag match)
- cache_wr_en  out  1  cache fill write enable
- cache_wr_idx  out  IDX_W  fill index
- cache_wr_tag  out  TAG_W  fill tag
- cache_wr_data  out  64  fill data
- proc2Imem_command  out  2  0 = BUS_NONE, 1 = BUS_LOAD
- proc2Imem_addr  out  64  miss block address, bits [2:0] = 0
- Imem2proc_response  in  MTAG_W  nonzero = load accepted, carrying the assigned tag
- Imem2proc_data  in  64  returning block
- Imem2proc_tag  in  MTAG_W  tag of the returning block; 0 = none

Behaviour:
- Read path is combinational:
  - cache_rd_idx = addr[9:3]; cache_rd_tag = addr[31:10].
  - Icache_data_out = cache_rd_data.
  - Icache_valid_out = cache_rd_valid, in every state.
- Registers: state, miss_addr[63:3], pend_tag[MTAG_W-1:0].
- Reset values: state IDLE, pend_tag 0, miss_addr 0.
  - During reset all outputs except the rd_* passthroughs are 0: command BUS_NONE, wr_en 0, proc2Imem_addr 0.
- State IDLE:
  - If cache_rd_valid = 0, latch miss_addr <= addr[63:3] and go to REQ.
  - Otherwise stay in IDLE.
- State REQ:
  - Drive proc2Imem_command = BUS_LOAD and proc2Imem_addr = {miss_addr, 3'b0}.
  - If Imem2proc_response != 0: pend_tag <= response, go to WAIT.
  - If response == 0 and addr[63:3] != miss_addr (fetch redirected before acceptance): abandon, relatch miss_addr to the new block, stay in REQ. If the new address hits, go to IDLE instead.
  - If response != 0 and the address also changed the same cycle, acceptance wins: go to WAIT for the old block.
- State WAIT:
  - Command is BUS_NONE.
  - When Imem2proc_tag == pend_tag (pend_tag is always nonzero here):
    - cache_wr_en = 1 for that cycle, cache_wr_idx/tag taken from miss_addr, cache_wr_data = Imem2proc_data.
    - pend_tag <= 0, go to IDLE.
  - A redirect during WAIT does not cancel the fill; the stale block is still written.
  - Non-matching tags are ignored.
- Fill write is combinational in the matching cycle. The cache memory registers it at the next edge, so the line hits from the following cycle.
- Reset asserted mid-miss returns to IDLE immediately. A later bus return with the stale tag is ignored because pend_tag = 0.
- Only one BUS_LOAD is outstanding at any time. The command is never asserted in IDLE or WAIT.

Optional Feature:
- Macro: ICACHE_FWD_EN.
- With the macro, in the WAIT fill cycle, if addr[63:3] == miss_addr:
  - Icache_valid_out = 1 and Icache_data_out = Imem2proc_data in that same cycle.
  - This saves one cycle of miss latency.
- Without the macro, the fill cycle shows the cache read result only, normally a miss. Valid is asserted on the next cycle from the cache.

Test Plan:
- Reset, addr=0x100, cache_rd_valid=0 -> cycle 1 REQ: command=1, proc2Imem_addr=0x100. Response=3 -> WAIT, command=0. Imem2proc_tag=3 with data=0xDEADBEEF_CAFEF00D -> wr_en=1, wr_idx=0x20, wr_tag=0, wr_data=0xDEADBEEF_CAFEF00D. Next cycle state IDLE.
- Hit: addr=0x108, cache_rd_valid=1, rd_data=0x1234 -> valid_out=1, data_out=0x1234, command stays 0 for 10 cycles.
- Bus back-pressure: response=0 for 5 cycles in REQ -> command=1 held with constant addr 0x100. Response=7 on cycle 6 -> pend_tag=7; tags 3 and 5 arriving later produce no wr_en.
- Redirect in REQ: addr 0x100 -> 0x400 with response=0 -> next cycle proc2Imem_addr=0x400. Redirect in WAIT (pend 2) -> fill to idx 0x20 still happens on tag 2.
- Reset during WAIT (pend_tag 4) -> IDLE. Later Imem2proc_tag=4 -> no wr_en while the address hits.
- With ICACHE_FWD_EN, matching fill cycle at unchanged addr 0x100 -> valid_out=1, data_out=Imem2proc_data in the same cycle. Without the macro -> valid_out=0 that cycle, 1 the next.

Source files
------------

// File: rtl/icache_ctrl_if.sv
// Signal bundle between icache_ctrl and the fetch stage, cache memory and instruction bus.
// master = controller view, slave = environment view.
interface icache_ctrl_if #(
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned TAG_W  = 22,
  parameter int unsigned MTAG_W = 4
);
  logic [63:0]       proc2Icache_addr;
  logic [63:0]       Icache_data_out;
  logic              Icache_valid_out;
  logic [IDX_W-1:0]  cache_rd_idx;
  logic [TAG_W-1:0]  cache_rd_tag;
  logic [63:0]       cache_rd_data;
  logic              cache_rd_valid;
  logic              cache_wr_en;
  logic [IDX_W-1:0]  cache_wr_idx;
  logic [TAG_W-1:0]  cache_wr_tag;
  logic [63:0]       cache_wr_data;
  logic [1:0]        proc2Imem_command;
  logic [63:0]       proc2Imem_addr;
  logic [MTAG_W-1:0] Imem2proc_response;
  logic [63:0]       Imem2proc_data;
  logic [MTAG_W-1:0] Imem2proc_tag;

  modport master (
    input  proc2Icache_addr, cache_rd_data, cache_rd_valid,
    input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
    output Icache_data_out, Icache_valid_out, cache_rd_idx, cache_rd_tag,
    output cache_wr_en, cache_wr_idx, cache_wr_tag, cache_wr_data,
    output proc2Imem_command, proc2Imem_addr
  );

  modport slave (
    output proc2Icache_addr, cache_rd_data, cache_rd_valid,
    output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
    input  Icache_data_out, Icache_valid_out, cache_rd_idx, cache_rd_tag,
    input  cache_wr_en, cache_wr_idx, cache_wr_tag, cache_wr_data,
    input  proc2Imem_command, proc2Imem_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Instruction cache miss controller: one outstanding bus load, tag-matched fill into cache memory.
// Define ICACHE_FWD_EN to forward the fill block to fetch in the fill cycle.
module icache_ctrl #(
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned TAG_W  = 22,
  parameter int unsigned MTAG_W = 4
) (
  input logic           clock,
  input logic           reset,
  icache_ctrl_if.master bus
);

  localparam int unsigned BLK_W    = 61;
  localparam logic [1:0]  BUS_NONE = 2'd0;
  localparam logic [1:0]  BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state;
  logic [BLK_W-1:0]  miss_addr;
  logic [MTAG_W-1:0] pend_tag;
  logic              cmd_load;
  logic [63:0]       req_addr;

  logic [BLK_W-1:0]  blk;
  logic              fill;
  logic              unused_addr_lsb;

  assign blk             = bus.proc2Icache_addr[63:3];
  assign unused_addr_lsb = ^bus.proc2Icache_addr[2:0];

  // pend_tag is nonzero whenever state is StWait, so tag 0 on the bus never matches here
  assign fill = !reset && (state == StWait) && (bus.Imem2proc_tag == pend_tag);

  assign bus.cache_rd_idx = bus.proc2Icache_addr[IDX_W+2:3];
  assign bus.cache_rd_tag = bus.proc2Icache_addr[IDX_W+TAG_W+2:IDX_W+3];

  assign bus.proc2Imem_command = (cmd_load && !reset) ? BUS_LOAD : BUS_NONE;
  assign bus.proc2Imem_addr    = reset ? '0 : req_addr;

  assign bus.cache_wr_en   = fill;
  assign bus.cache_wr_idx  = fill ? miss_addr[IDX_W-1:0] : '0;
  assign bus.cache_wr_tag  = fill ? miss_addr[IDX_W+TAG_W-1:IDX_W] : '0;
  assign bus.cache_wr_data = fill ? bus.Imem2proc_data : '0;

`ifdef ICACHE_FWD_EN
  logic fwd;
  assign fwd                  = fill && (blk == miss_addr);
  assign bus.Icache_valid_out = bus.cache_rd_valid | fwd;
  assign bus.Icache_data_out  = fwd ? bus.Imem2proc_data : bus.cache_rd_data;
`else
  assign bus.Icache_valid_out = bus.cache_rd_valid;
  assign bus.Icache_data_out  = bus.cache_rd_data;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= StIdle;
      miss_addr <= '0;
      pend_tag  <= '0;
      cmd_load  <= 1'b0;
      req_addr  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (!bus.cache_rd_valid) begin
            state     <= StReq;
            miss_addr <= blk;
            cmd_load  <= 1'b1;
            req_addr  <= {blk, 3'b000};
          end
        end
        StReq: begin
          // Acceptance beats a same-cycle redirect: the old block is still fetched
          if (bus.Imem2proc_response != '0) begin
            state    <= StWait;
            pend_tag <= bus.Imem2proc_response;
            cmd_load <= 1'b0;
            req_addr <= '0;
          end else if (blk != miss_addr) begin
            if (bus.cache_rd_valid) begin
              state    <= StIdle;
              cmd_load <= 1'b0;
              req_addr <= '0;
            end else begin
              miss_addr <= blk;
              req_addr  <= {blk, 3'b000};
            end
          end
        end
        StWait: begin
          if (fill) begin
            state    <= StIdle;
            pend_tag <= '0;
          end
        end
        default: begin
          state    <= StIdle;
          pend_tag <= '0;
          cmd_load <= 1'b0;
          req_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus a randomized run against
// a transaction-level model of the miss handler and a behavioural cache memory.
module tb_icache_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  icache_ctrl_if #(.IDX_W(7), .TAG_W(22), .MTAG_W(4)) bus ();

  icache_ctrl #(.IDX_W(7), .TAG_W(22), .MTAG_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [63:0] addr, input logic rd_v, input logic [63:0] rd_d,
                       input logic [3:0] resp, input logic [3:0] itag, input logic [63:0] idata);
    bus.proc2Icache_addr   = addr;
    bus.cache_rd_valid     = rd_v;
    bus.cache_rd_data      = rd_d;
    bus.Imem2proc_response = resp;
    bus.Imem2proc_tag      = itag;
    bus.Imem2proc_data     = idata;
    #1;
  endtask

  function automatic logic [63:0] memval(input logic [60:0] b);
    return {~b[31:0], b[31:0] ^ 32'h5A5A_A5A5};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive(64'h100, 1'b0, 64'h0, 4'd3, 4'd0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.proc2Imem_command !== 2'd0 || bus.proc2Imem_addr !== 64'h0
          || bus.cache_wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: cmd=%0d addr=%h wr_en=%b, want 0/0/0",
                 bus.proc2Imem_command, bus.proc2Imem_addr, bus.cache_wr_en);
      end
      tick();
    end
    n_checks++;
    if (bus.cache_rd_idx !== 7'h20 || bus.cache_rd_tag !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_rd_passthru: idx=%h tag=%h, want 20/0", bus.cache_rd_idx,
               bus.cache_rd_tag);
    end
  endtask

  task automatic test_miss_fill();
    logic exp_v;
    logic [63:0] exp_d;
    drive(64'h100, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.proc2Imem_command !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_cmd: got %0d want 0", bus.proc2Imem_command);
    end
    tick();
    n_checks++;
    if (bus.proc2Imem_command !== 2'd1 || bus.proc2Imem_addr !== 64'h100) begin
      n_fail++;
      $display("FAIL req_issue: cmd=%0d addr=%h, want 1/100", bus.proc2Imem_command,
               bus.proc2Imem_addr);
    end
    drive(64'h100, 1'b0, 64'h0, 4'd3, 4'd0, 64'h0);
    tick();
    drive(64'h100, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
    n_checks++;
    if (bus.proc2Imem_command !== 2'd0 || bus.cache_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle_bus: cmd=%0d wr_en=%b, want 0/0", bus.proc2Imem_command,
               bus.cache_wr_en);
    end
    drive(64'h100, 1'b0, 64'h0, 4'd0, 4'd3, 64'hDEADBEEF_CAFEF00D);
    n_checks++;
    if (bus.cache_wr_en !== 1'b1 || bus.cache_wr_idx !== 7'h20 || bus.cache_wr_tag !== 22'h0
        || bus.cache_wr_data !== 64'hDEADBEEF_CAFEF00D) begin
      n_fail++;
      $display("FAIL fill_write: en=%b idx=%h tag=%h data=%h, want 1/20/0/deadbeefcafef00d",
               bus.cache_wr_en, bus.cache_wr_idx, bus.cache_wr_tag, bus.cache_wr_data);
    end
`ifdef ICACHE_FWD_EN
    exp_v = 1'b1;
    exp_d = 64'hDEADBEEF_CAFEF00D;
`else
    exp_v = 1'b0;
    exp_d = 64'h0;
`endif
    n_checks++;
    if (bus.Icache_valid_out !== exp_v || bus.Icache_data_out !== exp_d) begin
      n_fail++;
      $display("FAIL fill_cycle_fetch: valid=%b data=%h, want %b/%h", bus.Icache_valid_out,
               bus.Icache_data_out, exp_v, exp_d);
    end
    tick();
    drive(64'h100, 1'b1, 64'hDEADBEEF_CAFEF00D, 4'd0, 4'd0, 64'h0);
    tick();
    n_checks++;
    if (bus.Icache_valid_out !== 1'b1 || bus.proc2Imem_command !== 2'd0) begin
      n_fail++;
      $display("FAIL post_fill_hit: valid=%b cmd=%0d, want 1/0", bus.Icache_valid_out,
               bus.proc2Imem_command);
    end
  endtask

  task automatic test_hit();
    drive(64'h108, 1'b1, 64'h1234, 4'd5, 4'd0, 64'h0);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.Icache_valid_out !== 1'b1 || bus.Icache_data_out !== 64'h1234
          || bus.proc2Imem_command !== 2'd0) begin
        n_fail++;
        $display("FAIL hit_cycle%0d: valid=%b data=%h cmd=%0d, want 1/1234/0", i,
                 bus.Icache_valid_out, bus.Icache_data_out, bus.proc2Imem_command);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    drive(64'h100, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.proc2Imem_command !== 2'd1 || bus.proc2Imem_addr !== 64'h100) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: cmd=%0d addr=%h, want 1/100", i,
                 bus.proc2Imem_command, bus.proc2Imem_addr);
      end
      tick();
    end
    drive(64'h100, 1'b0, 64'h0, 4'd7, 4'd0, 64'h0);
    tick();
    drive(64'h100, 1'b0, 64'h0, 4'd0, 4'd3, 64'h1);
    n_checks++;
    if (bus.cache_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_tag3: wr_en=%b want 0", bus.cache_wr_en);
    end
    tick();
    drive(64'h100, 1'b0, 64'h0, 4'd0, 4'd5, 64'h2);
    n_checks++;
    if (bus.cache_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_tag5: wr_en=%b want 0", bus.cache_wr_en);
    end
    tick();
    drive(64'h100, 1'b0, 64'h0, 4'd0, 4'd7, 64'h3);
    n_checks++;
    if (bus.cache_wr_en !== 1'b1 || bus.cache_wr_data !== 64'h3) begin
      n_fail++;
      $display("FAIL tag7_fill: wr_en=%b data=%h want 1/3", bus.cache_wr_en, bus.cache_wr_data);
    end
    tick();
    drive(64'h100, 1'b1, 64'h3, 4'd0, 4'd0, 64'h0);
    tick();
  endtask

  task automatic test_redirect();
    drive(64'h100, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
    tick();
    drive(64'h400, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
    tick();
    n_checks++;
    if (bus.proc2Imem_command !== 2'd1 || bus.proc2Imem_addr !== 64'h400) begin
      n_fail++;
      $display("FAIL req_redirect: cmd=%0d addr=%h, want 1/400", bus.proc2Imem_command,
               bus.proc2Imem_addr);
    end
    drive(64'h400, 1'b0, 64'h0, 4'd1, 4'd0, 64'h0);
    tick();
    drive(64'h400, 1'b0, 64'h0, 4'd0, 4'd1, 64'h44);
    n_checks++;
    if (bus.cache_wr_en !== 1'b1 || bus.cache_wr_idx !== 7'h00 || bus.cache_wr_tag !== 22'h1) begin
      n_fail++;
      $display("FAIL redirect_fill: en=%b idx=%h tag=%h, want 1/0/1", bus.cache_wr_en,
               bus.cache_wr_idx, bus.cache_wr_tag);
    end
    tick();
    // Redirect to a hitting address while still unaccepted drops the request
    drive(64'h100, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
    tick();
    drive(64'h108, 1'b1, 64'h9, 4'd0, 4'd0, 64'h0);
    tick();
    tick();
    n_checks++;
    if (bus.proc2Imem_command !== 2'd0) begin
      n_fail++;
      $display("FAIL redirect_to_hit: cmd=%0d want 0", bus.proc2Imem_command);
    end
    drive(64'h100, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
    tick();
    drive(64'h100, 1'b0, 64'h0, 4'd2, 4'd0, 64'h0);
    tick();
    drive(64'h800, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
    tick();
    drive(64'h800, 1'b0, 64'h0, 4'd0, 4'd2, 64'h77);
    n_checks++;
    if (bus.cache_wr_en !== 1'b1 || bus.cache_wr_idx !== 7'h20 || bus.Icache_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_redirect_fill: en=%b idx=%h valid=%b, want 1/20/0", bus.cache_wr_en,
               bus.cache_wr_idx, bus.Icache_valid_out);
    end
    tick();
    drive(64'h800, 1'b1, 64'h0, 4'd0, 4'd0, 64'h0);
    tick();
  endtask

  task automatic test_reset_mid_miss();
    drive(64'h100, 1'b0, 64'h0, 4'd0, 4'd0, 64'h0);
    tick();
    drive(64'h100, 1'b0, 64'h0, 4'd4, 4'd0, 64'h0);
    tick();
    reset = 1'b1;
    drive(64'h100, 1'b1, 64'h5, 4'd0, 4'd4, 64'h55);
    n_checks++;
    if (bus.cache_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_during_reset: wr_en=%b want 0", bus.cache_wr_en);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (bus.cache_wr_en !== 1'b0 || bus.proc2Imem_command !== 2'd0) begin
        n_fail++;
        $display("FAIL stale_after_reset%0d: wr_en=%b cmd=%0d, want 0/0", i, bus.cache_wr_en,
                 bus.proc2Imem_command);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic        cv[128];
    logic [21:0] ct[128];
    logic [63:0] cd[128];
    logic        m_req, m_wait, hit, fill, exp_v;
    logic [60:0] m_req_blk, m_wait_blk, blk;
    logic [3:0]  m_wait_tag, resp, itag;
    logic [63:0] addr, idata, exp_d, exp_a;
    logic [6:0]  idx;
    logic        rst;
    for (int i = 0; i < 128; i++) begin
      cv[i] = 1'b0;
      ct[i] = '0;
      cd[i] = '0;
    end
    // Start from a known idle controller
    reset = 1'b1;
    drive(64'h0, 1'b1, 64'h0, 4'd0, 4'd0, 64'h0);
    tick();
    reset = 1'b0;
    m_req = 1'b0;
    m_wait = 1'b0;
    m_req_blk = '0;
    m_wait_blk = '0;
    m_wait_tag = '0;
    addr = 64'h0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0)
        addr = (64'($urandom_range(0, 3)) << 10) | (64'($urandom_range(0, 7)) << 3);
      blk = addr[63:3];
      idx = addr[9:3];
      hit = cv[idx] && (ct[idx] == addr[31:10]);
      resp = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      itag = (m_wait && $urandom_range(0, 3) == 0) ? m_wait_tag : 4'($urandom_range(0, 15));
      idata = m_wait ? memval(m_wait_blk) : {32'($urandom), 32'($urandom)};
      reset = rst;
      drive(addr, hit, cd[idx], resp, itag, idata);

      fill = !rst && m_wait && (itag == m_wait_tag);
      exp_a = (!rst && m_req) ? {m_req_blk, 3'b000} : 64'h0;
      exp_v = hit;
      exp_d = cd[idx];
`ifdef ICACHE_FWD_EN
      if (fill && blk == m_wait_blk) begin
        exp_v = 1'b1;
        exp_d = idata;
      end
`endif
      n_checks++;
      if (bus.proc2Imem_command !== {1'b0, !rst && m_req} || bus.proc2Imem_addr !== exp_a) begin
        n_fail++;
        $display("FAIL rnd_bus c%0d: cmd=%0d addr=%h, want %0d/%h", c, bus.proc2Imem_command,
                 bus.proc2Imem_addr, !rst && m_req, exp_a);
      end
      n_checks++;
      if (bus.cache_wr_en !== fill) begin
        n_fail++;
        $display("FAIL rnd_wr_en c%0d: got %b want %b", c, bus.cache_wr_en, fill);
      end
      if (fill) begin
        n_checks++;
        if (bus.cache_wr_idx !== m_wait_blk[6:0] || bus.cache_wr_tag !== m_wait_blk[28:7]
            || bus.cache_wr_data !== memval(m_wait_blk)) begin
          n_fail++;
          $display("FAIL rnd_wr_fields c%0d: idx=%h tag=%h data=%h, want %h/%h/%h", c,
                   bus.cache_wr_idx, bus.cache_wr_tag, bus.cache_wr_data, m_wait_blk[6:0],
                   m_wait_blk[28:7], memval(m_wait_blk));
        end
      end
      n_checks++;
      if (bus.Icache_valid_out !== exp_v || bus.Icache_data_out !== exp_d) begin
        n_fail++;
        $display("FAIL rnd_fetch c%0d: valid=%b data=%h, want %b/%h", c, bus.Icache_valid_out,
                 bus.Icache_data_out, exp_v, exp_d);
      end

      tick();
      if (rst) begin
        m_req = 1'b0;
        m_wait = 1'b0;
      end else if (m_wait) begin
        if (fill) begin
          cv[m_wait_blk[6:0]] = 1'b1;
          ct[m_wait_blk[6:0]] = m_wait_blk[28:7];
          cd[m_wait_blk[6:0]] = memval(m_wait_blk);
          m_wait = 1'b0;
        end
      end else if (m_req) begin
        if (resp != 4'd0) begin
          m_wait = 1'b1;
          m_wait_blk = m_req_blk;
          m_wait_tag = resp;
          m_req = 1'b0;
        end else if (blk != m_req_blk) begin
          if (hit) m_req = 1'b0;
          else m_req_blk = blk;
        end
      end else if (!hit) begin
        m_req = 1'b1;
        m_req_blk = blk;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_backpressure();
    test_redirect();
    test_reset_mid_miss();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
